// File: rtl/accum_reducer.sv
// accum_reducer
//   Reduces NP consecutive input beats of NC signed WV-bit lanes into one
//   beat of NC signed WA-bit lane sums (WA = $clog2(NP)+WV). One input beat
//   per cycle; one result per NP accepted beats, latency 1 after the final
//   beat. Both sides use valid/ready handshakes.
//
// Ports
//   iCLK              clock, rising edge
//   iRST              asynchronous active-low reset
//   iValid_AS_Prod0   input beat valid
//   oReady_AS_Prod0   input beat accepted when high together with valid
//   iData_AS_Prod0    NC lanes, lane k at [k*WV +: WV], signed
//   oValid_BM_Accum0  result valid
//   iReady_BM_Accum0  downstream accepts result
//   oData_BM_Accum0   NC lanes, lane k at [k*WA +: WA], signed
module accum_reducer #(
  parameter int NP = 4,
  parameter int NC = 8,
  parameter int WV = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iValid_AS_Prod0,
  output logic               oReady_AS_Prod0,
  input  logic [NC*WV-1:0]   iData_AS_Prod0,
  output logic               oValid_BM_Accum0,
  input  logic               iReady_BM_Accum0,
  output logic [NC*(($clog2(NP))+WV)-1:0] oData_BM_Accum0
);

  localparam int WA = $clog2(NP) + WV;
  localparam int CW = $clog2(NP);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NC*WA-1:0] acc_q, acc_d;
  logic [NC*WA-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic             first_beat;
  logic             last_beat;
  logic             in_fire;
  logic             out_fire;
  logic [NC*WA-1:0] sum;

  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == CW'(NP - 1));

  // Only the final beat of a group can stall, and only while the previous
  // result is still waiting for the consumer.
  assign oReady_AS_Prod0 = ~last_beat | ~valid_q | iReady_BM_Accum0;

  assign in_fire  = iValid_AS_Prod0 & oReady_AS_Prod0;
  assign out_fire = valid_q & iReady_BM_Accum0;

  // Per-lane sign extension and add. On the first beat of a group the old
  // accumulator is ignored, so no separate clear cycle is needed.
  for (genvar k = 0; k < NC; k++) begin : g_lane
    logic [WV-1:0] in_l;
    logic [WA-1:0] ext;
    logic [WA-1:0] base;
    assign in_l = iData_AS_Prod0[k*WV +: WV];
    assign ext  = {{(WA-WV){in_l[WV-1]}}, in_l};
    assign base = first_beat ? '0 : acc_q[k*WA +: WA];
    assign sum[k*WA +: WA] = base + ext;
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;

    if (out_fire) begin
      valid_d = 1'b0;
    end

    if (in_fire) begin
      acc_d = sum;
      if (last_beat) begin
        cnt_d   = '0;
        data_d  = sum;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign oValid_BM_Accum0 = valid_q;
  assign oData_BM_Accum0  = data_q;

endmodule

// File: tb/tb_accum_reducer.sv
module tb_accum_reducer;

  localparam int NP = 4;
  localparam int NC = 8;
  localparam int WV = 4;
  localparam int WA = 6;

  logic               iCLK;
  logic               iRST;
  logic               iValid_AS_Prod0;
  logic               oReady_AS_Prod0;
  logic [NC*WV-1:0]   iData_AS_Prod0;
  logic               oValid_BM_Accum0;
  logic               iReady_BM_Accum0;
  logic [NC*WA-1:0]   oData_BM_Accum0;

  accum_reducer #(.NP(NP), .NC(NC), .WV(WV)) dut (
    .iCLK             (iCLK),
    .iRST             (iRST),
    .iValid_AS_Prod0  (iValid_AS_Prod0),
    .oReady_AS_Prod0  (oReady_AS_Prod0),
    .iData_AS_Prod0   (iData_AS_Prod0),
    .oValid_BM_Accum0 (oValid_BM_Accum0),
    .iReady_BM_Accum0 (iReady_BM_Accum0),
    .oData_BM_Accum0  (oData_BM_Accum0)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: accepted lane values of the current group, plus the
  // result register the consumer should currently see.
  int  beats_q[$];
  bit  m_valid;
  int  m_data[NC];

  function automatic logic [NC*WA-1:0] pack_out(input int s[NC]);
    logic [NC*WA-1:0] p;
    for (int k = 0; k < NC; k++) p[k*WA +: WA] = WA'(s[k]);
    return p;
  endfunction

  function automatic logic [NC*WV-1:0] in_all(input int x);
    logic [NC*WV-1:0] p;
    for (int k = 0; k < NC; k++) p[k*WV +: WV] = WV'(x);
    return p;
  endfunction

  function automatic logic [NC*WA-1:0] out_all(input int x);
    logic [NC*WA-1:0] p;
    for (int k = 0; k < NC; k++) p[k*WA +: WA] = WA'(x);
    return p;
  endfunction

  function automatic void model_reset();
    beats_q.delete();
    m_valid = 1'b0;
    for (int k = 0; k < NC; k++) m_data[k] = 0;
  endfunction

  function automatic void model_edge(input logic [NC*WV-1:0] d, input bit in_f, input bit out_f);
    logic [WV-1:0] lane;
    if (out_f) m_valid = 1'b0;
    if (in_f) begin
      for (int k = 0; k < NC; k++) begin
        lane = d[k*WV +: WV];
        beats_q.push_back(int'($signed(lane)));
      end
      if (beats_q.size() == NP*NC) begin
        for (int k = 0; k < NC; k++) begin
          int s = 0;
          for (int b = 0; b < NP; b++) s += beats_q[b*NC + k];
          m_data[k] = s;
        end
        m_valid = 1'b1;
        beats_q.delete();
      end
    end
  endfunction

  // One clock cycle: drive, check at the falling edge, advance model after
  // the rising edge. Returns what was observed at the falling edge.
  task automatic cyc(input bit v, input logic [NC*WV-1:0] d, input bit r,
                     output bit sv, output logic [NC*WA-1:0] sd);
    bit exp_ready, in_f, out_f;
    iValid_AS_Prod0  = v;
    iData_AS_Prod0   = d;
    iReady_BM_Accum0 = r;
    @(negedge iCLK);
    exp_ready = (beats_q.size() != (NP-1)*NC) || !m_valid || r;
    chk("ready", 64'(oReady_AS_Prod0), 64'(exp_ready));
    chk("valid", 64'(oValid_BM_Accum0), 64'(m_valid));
    if (m_valid) chk("data", 64'(oData_BM_Accum0), 64'(pack_out(m_data)));
    sv = oValid_BM_Accum0;
    sd = oData_BM_Accum0;
    in_f  = v && exp_ready;
    out_f = m_valid && r;
    @(posedge iCLK);
    #1;
    model_edge(d, in_f, out_f);
  endtask

  typedef struct {
    bit               v;
    logic [NC*WV-1:0] d;
    bit               r;
    bit               ev;
    logic [NC*WA-1:0] ed;
  } vec_t;

  vec_t tbl[18];

  initial begin
    bit               sv;
    logic [NC*WA-1:0] sd;
    logic [NC*WV-1:0] basic_in;
    logic [NC*WA-1:0] basic_out;
    int               nres;

    for (int k = 0; k < NC; k++) begin
      basic_in[k*WV +: WV]  = WV'(k - 4);
      basic_out[k*WA +: WA] = WA'(4 * (k - 4));
    end

    // Basic sum, then -8 x4, +7 x4, alternating +7/-8; each result shows
    // one cycle after its final beat.
    tbl[0]  = '{1'b1, basic_in,   1'b1, 1'b0, '0};
    tbl[1]  = '{1'b1, basic_in,   1'b1, 1'b0, '0};
    tbl[2]  = '{1'b1, basic_in,   1'b1, 1'b0, '0};
    tbl[3]  = '{1'b1, basic_in,   1'b1, 1'b0, '0};
    tbl[4]  = '{1'b1, in_all(-8), 1'b1, 1'b1, basic_out};
    tbl[5]  = '{1'b1, in_all(-8), 1'b1, 1'b0, '0};
    tbl[6]  = '{1'b1, in_all(-8), 1'b1, 1'b0, '0};
    tbl[7]  = '{1'b1, in_all(-8), 1'b1, 1'b0, '0};
    tbl[8]  = '{1'b1, in_all(7),  1'b1, 1'b1, out_all(-32)};
    tbl[9]  = '{1'b1, in_all(7),  1'b1, 1'b0, '0};
    tbl[10] = '{1'b1, in_all(7),  1'b1, 1'b0, '0};
    tbl[11] = '{1'b1, in_all(7),  1'b1, 1'b0, '0};
    tbl[12] = '{1'b1, in_all(7),  1'b1, 1'b1, out_all(28)};
    tbl[13] = '{1'b1, in_all(-8), 1'b1, 1'b0, '0};
    tbl[14] = '{1'b1, in_all(7),  1'b1, 1'b0, '0};
    tbl[15] = '{1'b1, in_all(-8), 1'b1, 1'b0, '0};
    tbl[16] = '{1'b0, '0,         1'b1, 1'b1, out_all(-2)};
    tbl[17] = '{1'b0, '0,         1'b1, 1'b0, '0};

    // Reset state
    iRST = 1'b0;
    iValid_AS_Prod0 = 1'b0;
    iData_AS_Prod0 = '0;
    iReady_BM_Accum0 = 1'b0;
    model_reset();
    #23;
    chk("rst_valid", 64'(oValid_BM_Accum0), 64'd0);
    chk("rst_data",  64'(oData_BM_Accum0), 64'd0);
    chk("rst_ready", 64'(oReady_AS_Prod0), 64'd1);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].r, sv, sd);
      chk($sformatf("tbl%0d_valid", i), 64'(sv), 64'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 64'(sd), 64'(tbl[i].ed));
    end

    // Backpressure: result 1 = 4*2 held, beat 8 stalls, one-cycle handshake
    // swaps in result 2 = 4*(-3) with no gap in valid.
    for (int i = 0; i < 4; i++) cyc(1'b1, in_all(2), 1'b0, sv, sd);
    for (int i = 0; i < 6; i++) cyc(1'b1, in_all(-3), 1'b0, sv, sd);
    chk("bp_stall_ready", 64'(oReady_AS_Prod0), 64'd0);
    chk("bp_hold_valid",  64'(oValid_BM_Accum0), 64'd1);
    chk("bp_hold_data",   64'(oData_BM_Accum0), 64'(out_all(8)));
    cyc(1'b1, in_all(-3), 1'b1, sv, sd);
    chk("bp_next_valid", 64'(oValid_BM_Accum0), 64'd1);
    chk("bp_next_data",  64'(oData_BM_Accum0), 64'(out_all(-12)));
    cyc(1'b0, '0, 1'b1, sv, sd);
    cyc(1'b0, '0, 1'b1, sv, sd);

    // Bubbles: garbage data on idle cycles must be ignored
    for (int b = 0; b < 4; b++) begin
      cyc(1'b1, in_all(b + 1), 1'b1, sv, sd);
      if (b < 3) begin
        cyc(1'b0, NC*WV'($urandom), 1'b1, sv, sd);
        cyc(1'b0, NC*WV'($urandom), 1'b1, sv, sd);
      end
    end
    cyc(1'b0, '0, 1'b1, sv, sd);
    chk("bubble_valid", 64'(sv), 64'd1);
    chk("bubble_data",  64'(sd), 64'(out_all(10)));

    // Async reset mid-group with a held result pending
    for (int i = 0; i < 4; i++) cyc(1'b1, in_all(5), 1'b0, sv, sd);
    cyc(1'b1, in_all(3), 1'b0, sv, sd);
    cyc(1'b1, in_all(3), 1'b0, sv, sd);
    iValid_AS_Prod0 = 1'b0;
    #2;
    iRST = 1'b0;
    #1;
    chk("arst_valid", 64'(oValid_BM_Accum0), 64'd0);
    chk("arst_data",  64'(oData_BM_Accum0), 64'd0);
    chk("arst_ready", 64'(oReady_AS_Prod0), 64'd1);
    model_reset();
    #1;
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    for (int i = 0; i < 4; i++) cyc(1'b1, in_all(1), 1'b1, sv, sd);
    cyc(1'b0, '0, 1'b1, sv, sd);
    chk("arst_sum_valid", 64'(sv), 64'd1);
    chk("arst_sum_data",  64'(sd), 64'(out_all(4)));

    // Streaming: 12 beats -> 3 results
    nres = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, NC*WV'($urandom), 1'b1, sv, sd);
      if (sv) nres++;
    end
    cyc(1'b0, '0, 1'b1, sv, sd);
    if (sv) nres++;
    chk("stream_results", 64'(nres), 64'd3);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, NC*WV'($urandom), $urandom_range(0, 2) != 0, sv, sd);
    end
    cyc(1'b0, '0, 1'b1, sv, sd);
    cyc(1'b0, '0, 1'b1, sv, sd);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
